brew_executor: RTL and testbench

BREW_EXECUTOR -- requirements
Module: brew_executor

---
 rtl/brew_executor.sv | 114 +++++++++++
 tb/tb_brew_executor.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/brew_executor.sv
// Brew sequencer: runs the requested phases T, W, F, M, O in fixed order, each for
// PHASE_CYCLES cycles, with abort and synchronous reset.
module brew_executor #(
    parameter int unsigned PHASE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [4:0] cmd,
    input  logic       abort,
    output logic       cmd_ready,
    output logic       t_en,
    output logic       w_en,
    output logic       f_en,
    output logic       m_en,
    output logic       o_en,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StT    = 3'd1,
        StW    = 3'd2,
        StF    = 3'd3,
        StM    = 3'd4,
        StO    = 3'd5,
        StDone = 3'd6
    } state_e;

    localparam logic [7:0] LoadVal = 8'(PHASE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [4:0] cmd_q, cmd_d;
    logic       aborted_q, aborted_d;

    // First requested phase strictly after 'from'; DONE when none remain.
    function automatic state_e next_phase(input state_e from, input logic [4:0] req);
        state_e nxt;
        if (from < StT && req[4]) begin
            nxt = StT;
        end else if (from < StW && req[3]) begin
            nxt = StW;
        end else if (from < StF && req[2]) begin
            nxt = StF;
        end else if (from < StM && req[1]) begin
            nxt = StM;
        end else if (from < StO && req[0]) begin
            nxt = StO;
        end else begin
            nxt = StDone;
        end
        return nxt;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        aborted_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    cmd_d   = cmd;
                    state_d = next_phase(StIdle, cmd);
                    cnt_d   = LoadVal;
                end
            end
            StT, StW, StF, StM, StO: begin
                if (abort) begin
                    state_d   = StIdle;
                    cnt_d     = 8'd0;
                    aborted_d = 1'b1;
                end else if (cnt_q == 8'd0) begin
                    state_d = next_phase(state_q, cmd_q);
                    cnt_d   = LoadVal;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            cmd_q     <= 5'd0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            aborted_q <= aborted_d;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign t_en      = (state_q == StT);
    assign w_en      = (state_q == StW);
    assign f_en      = (state_q == StF);
    assign m_en      = (state_q == StM);
    assign o_en      = (state_q == StO);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign aborted   = aborted_q;
    assign phase     = state_q;

endmodule

// File: tb/tb_brew_executor.sv
// Scoreboard bench for brew_executor: expected per-cycle outputs are queued per command
// and compared cycle by cycle; a monitor checks one-hot enables every cycle.
module tb_brew_executor;

    localparam int unsigned P = 4;

    logic       clk = 1'b0;
    logic       rst, cmd_valid, abort;
    logic [4:0] cmd;
    logic       cmd_ready, t_en, w_en, f_en, m_en, o_en, busy, done, aborted;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    brew_executor #(.PHASE_CYCLES(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .abort     (abort),
        .cmd_ready (cmd_ready),
        .t_en      (t_en),
        .w_en      (w_en),
        .f_en      (f_en),
        .m_en      (m_en),
        .o_en      (o_en),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .phase     (phase)
    );

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // {phase, t,w,f,m,o, busy, done, aborted, cmd_ready}
    function automatic logic [11:0] mk(input logic [2:0] ph, input logic ab);
        logic [4:0] en = 5'd0;
        if (ph >= 3'd1 && ph <= 3'd5) en = 5'b10000 >> (ph - 3'd1);
        return {ph, en, ph != 3'd0, ph == 3'd6, ab, ph == 3'd0};
    endfunction

    function automatic logic [11:0] observe();
        return {phase, t_en, w_en, f_en, m_en, o_en, busy, done, aborted, cmd_ready};
    endfunction

    always @(negedge clk) begin
        check_eq("onehot", {11'd0, ($countones({t_en, w_en, f_en, m_en, o_en}) <= 1)
                                   && !(done && aborted)}, 12'd1);
    end

    task automatic push_seq(input logic [4:0] c);
        for (int b = 4; b >= 0; b--) begin
            if (c[b]) repeat (P) exp_q.push_back(mk(3'(5 - b), 1'b0));
        end
        exp_q.push_back(mk(3'd6, 1'b0));
        exp_q.push_back(mk(3'd0, 1'b0));
    endtask

    task automatic run(input logic [4:0] c, input int abort_cyc, input int rst_cyc,
                       input bit hold, input bit abort_acc);
        logic [11:0] e;
        int k;
        push_seq(c);
        if (abort_cyc > 0) begin
            while (exp_q.size() > abort_cyc) void'(exp_q.pop_back());
            exp_q.push_back(mk(3'd0, 1'b1));
            exp_q.push_back(mk(3'd0, 1'b0));
        end
        if (rst_cyc > 0) begin
            while (exp_q.size() > rst_cyc) void'(exp_q.pop_back());
            exp_q.push_back(mk(3'd0, 1'b0));
        end
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd       = c;
        abort     = abort_acc;
        @(posedge clk);
        #1;
        abort = 1'b0;
        if (!hold) cmd_valid = 1'b0;
        k = 1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check_eq($sformatf("cmd%b_cyc%0d", c, k), observe(), e);
            if (exp_q.size() == 0) cmd_valid = 1'b0;
            else if (hold) cmd = 5'($urandom);
            if (k == abort_cyc) abort = 1'b1;
            if (k == rst_cyc) rst = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            rst   = 1'b0;
            k++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd       = 5'd0;
        abort     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("reset", observe(), mk(3'd0, 1'b0));
        // Reset beats a simultaneous command and abort.
        cmd_valid = 1'b1;
        cmd       = 5'b11111;
        abort     = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_prio", observe(), mk(3'd0, 1'b0));
        rst       = 1'b0;
        cmd_valid = 1'b0;
        abort     = 1'b0;

        run(5'b11111, 0, 0, 1'b0, 1'b0);
        run(5'b10001, 0, 0, 1'b0, 1'b0);
        run(5'b00000, 0, 0, 1'b0, 1'b0);
        run(5'b01100, 6, 0, 1'b0, 1'b0);
        run(5'b10000, 0, 3, 1'b0, 1'b0);
        run(5'b11111, 0, 0, 1'b0, 1'b0);
        run(5'b01010, 0, 0, 1'b1, 1'b0);
        run(5'b00100, 0, 0, 1'b0, 1'b1);
        run(5'b00011, 2, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
